// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial deserializer: controller state encoding.
// Imported by deser_datapath and serial_deserializer.
package serial_deser_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // PARITY is only entered in PARITY_CHECK_EN builds.
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY,
    HOLD   = ST_HOLD
  } deser_state_e;

endpackage

// File: rtl/deser_datapath.sv
// Datapath of the serial deserializer: shift register, bit counter, last-bit
// flag, output word register and (PARITY_CHECK_EN builds) a running XOR of
// the data bits.
// Ports:
//   clk, reset       clock, async active-high reset
//   clr              clear shift reg, count (and parity accumulator)
//   shift            shift bit_in in, count++
//   capture          load data_out with the completed word
//   bit_in           serial data bit
//   last_bit         count == WIDTH-1 (next shifted bit completes the word)
//   par_acc          XOR of data bits so far (PARITY_CHECK_EN only)
//   data_out         captured word
// Optional feature macro: PARITY_CHECK_EN.
module deser_datapath
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             capture,
  input  logic             bit_in,
  output logic             last_bit,
`ifdef PARITY_CHECK_EN
  output logic             par_acc,
`endif
  output logic [WIDTH-1:0] data_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    count;

  // MSB-first: first bit migrates up to bit WIDTH-1; LSB-first: down to bit 0.
  always_comb begin
    sr_nxt = (LSB_FIRST != 0) ? {bit_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bit_in};
  end

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      count    <= '0;
      data_out <= '0;
`ifdef PARITY_CHECK_EN
      par_acc  <= 1'b0;
`endif
    end else begin
      if (clr) begin
        sr      <= '0;
        count   <= '0;
`ifdef PARITY_CHECK_EN
        par_acc <= 1'b0;
`endif
      end else if (shift) begin
        sr      <= sr_nxt;
        count   <= count + CW'(1);
`ifdef PARITY_CHECK_EN
        par_acc <= par_acc ^ bit_in;
`endif
      end
      // Capture on the final data bit takes the word including that bit.
      if (capture) data_out <= shift ? sr_nxt : sr;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial deserializer: collects a serial bit stream into a WIDTH-bit word and
// presents it on a valid/ready handshake. Controller FSM lives here; the
// datapath is in deser_datapath.
// Ports:
//   clk, reset     clock, async active-high reset
//   start          1-cycle pulse, begin (or restart) a frame
//   serial_in      serial bit, sampled when bit_valid=1
//   bit_valid      serial bit strobe
//   data_out       assembled word, stable while data_valid=1
//   data_valid     word ready for consumer
//   data_ready     consumer accepts on data_valid & data_ready
//   busy           1 while receiving bits (SHIFT / PARITY)
//   overrun        sticky: start seen while a word was unaccepted
//   parity_err     (PARITY_CHECK_EN only) even-parity failure, valid with data_valid
// Optional feature macro: PARITY_CHECK_EN (adds one even-parity bit per word).
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  deser_state_e state;
  logic clr, shift, capture, last_bit;
`ifdef PARITY_CHECK_EN
  logic par_acc;
`endif

  deser_datapath #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift    (shift),
    .capture  (capture),
    .bit_in   (serial_in),
    .last_bit (last_bit),
`ifdef PARITY_CHECK_EN
    .par_acc  (par_acc),
`endif
    .data_out (data_out)
  );

  // Datapath strobes. start always beats a coincident bit_valid.
  always_comb begin
    clr     = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:  clr = start;
      SHIFT: begin
        clr   = start;
        shift = bit_valid & ~start;
`ifndef PARITY_CHECK_EN
        capture = bit_valid & ~start & last_bit;
`endif
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        clr     = start;
        capture = bit_valid & ~start;
      end
`endif
      // A start is only honoured here if the current word is taken this cycle.
      HOLD:    clr = start & data_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (!start && bit_valid && last_bit) begin
`ifdef PARITY_CHECK_EN
            state      <= PARITY;
`else
            state      <= HOLD;
            data_valid <= 1'b1;
            busy       <= 1'b0;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (start) begin
            state <= SHIFT;
          end else if (bit_valid) begin
            state      <= HOLD;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            parity_err <= par_acc ^ serial_in;
          end
        end
`endif
        HOLD: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (start) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=8). Two instances share the
// stimulus: u_msb (LSB_FIRST=0) and u_lsb (LSB_FIRST=1).
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, serial_in = 1'b0, bit_valid = 1'b0, data_ready = 1'b0;
  logic [7:0] do_m, do_l;
  logic dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef PARITY_CHECK_EN
  logic pe_m, pe_l;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(do_m), .data_valid(dv_m),
    .data_ready(data_ready), .busy(busy_m),
`ifdef PARITY_CHECK_EN
    .parity_err(pe_m),
`endif
    .overrun(ovr_m)
  );

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(do_l), .data_valid(dv_l),
    .data_ready(data_ready), .busy(busy_l),
`ifdef PARITY_CHECK_EN
    .parity_err(pe_l),
`endif
    .overrun(ovr_l)
  );

  typedef struct {
    logic [7:0] seq;    // seq[7] is sent first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Eight data bits MSB of seq first, optional 0-3 idle cycles before each;
  // parity builds append the correct even-parity bit.
  task automatic send_bits(input logic [7:0] seq, input bit gapped);
    for (int i = 7; i >= 0; i--) begin
      if (gapped) repeat (i % 4) tick();
      send_bit(seq[i]);
    end
`ifdef PARITY_CHECK_EN
    send_bit(^seq);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{seq: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[1] = '{seq: 8'hC0, exp_m: 8'hC0, exp_l: 8'h03};
    vecs[2] = '{seq: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
    vecs[3] = '{seq: 8'h12, exp_m: 8'h12, exp_l: 8'h48};
    vecs[4] = '{seq: 8'hFF, exp_m: 8'hFF, exp_l: 8'hFF};

    // Reset state
    #1;
    chk("rst_data_out", do_m, 8'h00);
    chk("rst_valid", 8'(dv_m), 8'h0);
    chk("rst_busy", 8'(busy_m), 8'h0);
    chk("rst_overrun", 8'(ovr_m), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table: back-to-back bits, consumer always ready
    data_ready = 1'b1;
    foreach (vecs[k]) begin
      start_frame();
      chk($sformatf("v%0d_busy_in_frame", k), 8'(busy_m), 8'h1);
      send_bits(vecs[k].seq, 1'b0);
      chk($sformatf("v%0d_valid", k), 8'(dv_m), 8'h1);
      chk($sformatf("v%0d_valid_lsb", k), 8'(dv_l), 8'h1);
      chk($sformatf("v%0d_data_msb", k), do_m, vecs[k].exp_m);
      chk($sformatf("v%0d_data_lsb", k), do_l, vecs[k].exp_l);
      chk($sformatf("v%0d_busy_done", k), 8'(busy_l), 8'h0);
      tick();
      chk($sformatf("v%0d_valid_one_cycle", k), 8'(dv_m), 8'h0);
    end

    // Gapped bits, consumer stalls 5 cycles
    data_ready = 1'b0;
    start_frame();
    send_bits(8'h96, 1'b1);
    chk("gap_valid", 8'(dv_m), 8'h1);
    chk("gap_data_msb", do_m, 8'h96);
    chk("gap_data_lsb", do_l, 8'h69);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d_valid", c), 8'(dv_m), 8'h1);
      chk($sformatf("stall%0d_data", c), do_m, 8'h96);
    end
    data_ready = 1'b1;
    tick();
    chk("stall_accept_valid", 8'(dv_m), 8'h0);
    chk("stall_accept_busy", 8'(busy_m), 8'h0);

    // Abort after 4 bits; restart coincides with a bit strobe that is dropped
    start_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    start = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
    chk("abort_busy", 8'(busy_m), 8'h1);
    chk("abort_no_valid", 8'(dv_m), 8'h0);
    send_bits(8'h3C, 1'b0);
    chk("abort_valid", 8'(dv_m), 8'h1);
    chk("abort_data_msb", do_m, 8'h3C);
    chk("abort_data_lsb", do_l, 8'h3C);
    tick();

    // Overrun: start while holding an unaccepted word
    data_ready = 1'b0;
    start_frame();
    send_bits(8'h5A, 1'b0);
    chk("ovr_pre", 8'(ovr_m), 8'h0);
    start_frame();
    chk("ovr_set", 8'(ovr_m), 8'h1);
    chk("ovr_set_lsb", 8'(ovr_l), 8'h1);
    chk("ovr_word_kept", do_m, 8'h5A);
    chk("ovr_valid_kept", 8'(dv_m), 8'h1);
    chk("ovr_not_busy", 8'(busy_m), 8'h0);
    start = 1'b1; data_ready = 1'b1;
    tick();
    start = 1'b0; data_ready = 1'b0;
    chk("handoff_valid", 8'(dv_m), 8'h0);
    chk("handoff_busy", 8'(busy_m), 8'h1);
    chk("handoff_ovr_sticky", 8'(ovr_m), 8'h1);
    send_bits(8'h81, 1'b0);
    chk("handoff_data", do_m, 8'h81);
    chk("handoff_ovr_still", 8'(ovr_m), 8'h1);
    data_ready = 1'b1;
    tick();
    chk("handoff_accept", 8'(dv_m), 8'h0);

    // Async reset mid-frame
    start_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", do_m, 8'h00);
    chk("async_rst_data_lsb", do_l, 8'h00);
    chk("async_rst_busy", 8'(busy_m), 8'h0);
    chk("async_rst_valid", 8'(dv_m), 8'h0);
    chk("async_rst_ovr", 8'(ovr_m), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    start_frame();
    send_bits(8'hFF, 1'b0);
    chk("post_rst_valid", 8'(dv_m), 8'h1);
    chk("post_rst_data", do_m, 8'hFF);
    tick();

`ifdef PARITY_CHECK_EN
    // Parity bit 0 on A5 (even) is good, parity bit 1 is an error
    for (int p = 0; p < 2; p++) begin
      start_frame();
      for (int i = 7; i >= 0; i--) begin
        logic [7:0] w;
        w = 8'hA5;
        send_bit(w[i]);
      end
      chk($sformatf("par%0d_wait", p), 8'(dv_m), 8'h0);
      send_bit(p[0]);
      chk($sformatf("par%0d_valid", p), 8'(dv_m), 8'h1);
      chk($sformatf("par%0d_data", p), do_m, 8'hA5);
      chk($sformatf("par%0d_err", p), 8'(pe_m), 8'(p));
      chk($sformatf("par%0d_err_lsb", p), 8'(pe_l), 8'(p));
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
